// File: rtl/rr_decoder_arbiter_pkg.sv
// Shared sizes and FSM state encoding for the round-robin arbiter.
package rr_decoder_arbiter_pkg;
  localparam int NUM_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;
endpackage

// File: rtl/decoder.sv
// 3-to-8 one-hot decoder; purely combinational, no flow control.
module decoder (
  input  logic [2:0] sel_i,
  output logic [7:0] dec_o
);
  assign dec_o = 8'b0000_0001 << sel_i;
endmodule

// File: rtl/rr_decoder_arbiter_pick.sv
// Round-robin pick: first set request after ptr (mod 8); combinational, zero latency.
module rr_pick
  import rr_decoder_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   pick_o,
  output logic               any_o
);
  logic [IDX_W-1:0]   start;
  logic [IDX_W-1:0]   off;
  logic [NUM_REQ-1:0] rot;

  assign start = ptr_i + 1'b1;

  // rot[0] is the highest-priority requester (ptr+1); index arithmetic wraps at 3 bits
  always_comb begin
    rot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rot[i] = req_i[start + IDX_W'(i)];
    end
  end

  always_comb begin
    off = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = IDX_W'(i);
    end
  end

  assign pick_o = start + off;
  assign any_o  = |req_i;
endmodule

// File: rtl/rr_decoder_arbiter.sv
// 8-way round-robin arbiter with hold limit; grant appears 1 cycle after request,
// one dead IDLE cycle after every release, non-owner requests ignored while granted.
module rr_decoder_arbiter
  import rr_decoder_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               timeout
);
  localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

  state_e             state_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [IDX_W-1:0]   idx_q;
  logic [HOLD_W-1:0]  hold_q;
  logic [HOLD_W-1:0]  hold_d;
  logic               timeout_q;
  logic [IDX_W-1:0]   pick;
  logic               any;
  logic               hold_at_limit;
  logic [NUM_REQ-1:0] dec;

  rr_pick u_pick (
    .req_i  (req),
    .ptr_i  (ptr_q),
    .pick_o (pick),
    .any_o  (any)
  );

  // Saturate rather than wrap so an unlimited hold never aliases back to a small count
  assign hold_d        = (hold_q == '1) ? hold_q : hold_q + 1'b1;
  assign hold_at_limit = (MAX_HOLD != 0) && (hold_q == HOLD_LIM);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= IDX_W'(NUM_REQ - 1);
      idx_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (any) begin
            state_q <= GRANT;
            idx_q   <= pick;
            ptr_q   <= pick;
            hold_q  <= HOLD_W'(1);
          end
        end
        GRANT: begin
          // Owner dropping req wins over the hold limit: normal release, no timeout
          if (!req[idx_q]) begin
            state_q <= IDLE;
          end else if (hold_at_limit) begin
            state_q   <= IDLE;
            timeout_q <= 1'b1;
          end else begin
            hold_q <= hold_d;
          end
        end
      endcase
    end
  end

  decoder u_dec (
    .sel_i (idx_q),
    .dec_o (dec)
  );

  assign gnt_valid = (state_q == GRANT);
  assign gnt_idx   = idx_q;
  assign gnt       = dec & {NUM_REQ{gnt_valid}};
  assign timeout   = timeout_q;
endmodule

// File: tb/tb_rr_decoder_arbiter.sv
// Directed bench: dut0 has unlimited hold, dut4 has MAX_HOLD=4; both share inputs.
module tb_rr_decoder_arbiter;
  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic [7:0] gnt0, gnt4;
  logic [2:0] idx0, idx4;
  logic       vld0, vld4;
  logic       to0, to4;
  int         n_vec = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  rr_decoder_arbiter #(.MAX_HOLD(0), .HOLD_W(5)) dut0 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt0), .gnt_idx(idx0), .gnt_valid(vld0), .timeout(to0)
  );

  rr_decoder_arbiter #(.MAX_HOLD(4), .HOLD_W(5)) dut4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .gnt(gnt4), .gnt_idx(idx4), .gnt_valid(vld4), .timeout(to4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req   = 8'h00;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    tick();
    tick();
    n_vec++; if (gnt0 !== 8'h00) begin n_err++; $display("FAIL reset_gnt0 got=%h exp=00", gnt0); end
    n_vec++; if (vld0 !== 1'b0)  begin n_err++; $display("FAIL reset_vld0 got=%b exp=0", vld0); end
    n_vec++; if (to0 !== 1'b0)   begin n_err++; $display("FAIL reset_to0 got=%b exp=0", to0); end
    n_vec++; if (gnt4 !== 8'h00) begin n_err++; $display("FAIL reset_gnt4 got=%h exp=00", gnt4); end
    n_vec++; if (idx0 !== 3'd0)  begin n_err++; $display("FAIL reset_idx0 got=%0d exp=0", idx0); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (gnt0 !== 8'h01) begin n_err++; $display("FAIL reset_first_gnt got=%h exp=01", gnt0); end
    n_vec++; if (idx0 !== 3'd0)  begin n_err++; $display("FAIL reset_first_idx got=%0d exp=0", idx0); end
    n_vec++; if (vld0 !== 1'b1)  begin n_err++; $display("FAIL reset_first_vld got=%b exp=1", vld0); end
  endtask

  task automatic test_rotation();
    logic [2:0] exp_idx;
    logic [7:0] exp_gnt;
    do_reset();
    req = 8'h05;
    tick();
    for (int r = 0; r < 4; r++) begin
      exp_idx = (r % 2 == 0) ? 3'd0 : 3'd2;
      exp_gnt = (r % 2 == 0) ? 8'h01 : 8'h04;
      for (int c = 0; c < 3; c++) begin
        n_vec++; if (gnt0 !== exp_gnt) begin n_err++; $display("FAIL rot_gnt r=%0d c=%0d got=%h exp=%h", r, c, gnt0, exp_gnt); end
        n_vec++; if (idx0 !== exp_idx) begin n_err++; $display("FAIL rot_idx r=%0d c=%0d got=%0d exp=%0d", r, c, idx0, exp_idx); end
        if (c < 2) tick();
      end
      req = 8'h05 & ~exp_gnt;
      tick();
      n_vec++; if (gnt0 !== 8'h00) begin n_err++; $display("FAIL rot_idle_gnt r=%0d got=%h exp=00", r, gnt0); end
      n_vec++; if (vld0 !== 1'b0)  begin n_err++; $display("FAIL rot_idle_vld r=%0d got=%b exp=0", r, vld0); end
      req = 8'h05;
      tick();
    end
  endtask

  task automatic test_single();
    do_reset();
    req = 8'h80;
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (k == 4) req = 8'h00;
      n_vec++; if (gnt0 !== 8'h80) begin n_err++; $display("FAIL single_gnt k=%0d got=%h exp=80", k, gnt0); end
      n_vec++; if (idx0 !== 3'd7)  begin n_err++; $display("FAIL single_idx k=%0d got=%0d exp=7", k, idx0); end
    end
    tick();
    n_vec++; if (gnt0 !== 8'h00) begin n_err++; $display("FAIL single_release got=%h exp=00", gnt0); end
    n_vec++; if (to4 !== 1'b0)   begin n_err++; $display("FAIL single_to4 got=%b exp=0", to4); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp_g [11] = '{8'h02, 8'h02, 8'h02, 8'h02, 8'h00,
                               8'h10, 8'h10, 8'h10, 8'h10, 8'h00, 8'h02};
    logic       exp_t [11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                               1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    req = 8'h12;
    for (int k = 0; k < 11; k++) begin
      tick();
      n_vec++; if (gnt4 !== exp_g[k]) begin n_err++; $display("FAIL tmo_gnt k=%0d got=%h exp=%h", k, gnt4, exp_g[k]); end
      n_vec++; if (to4 !== exp_t[k])  begin n_err++; $display("FAIL tmo_pulse k=%0d got=%b exp=%b", k, to4, exp_t[k]); end
    end
    n_vec++; if (to0 !== 1'b0) begin n_err++; $display("FAIL tmo_unlimited got=%b exp=0", to0); end
  endtask

  task automatic test_timeout_boundary();
    do_reset();
    req = 8'h12;
    for (int k = 1; k <= 4; k++) tick();
    n_vec++; if (gnt4 !== 8'h02) begin n_err++; $display("FAIL bnd_owner got=%h exp=02", gnt4); end
    req = 8'h10;
    tick();
    n_vec++; if (gnt4 !== 8'h00) begin n_err++; $display("FAIL bnd_idle got=%h exp=00", gnt4); end
    n_vec++; if (to4 !== 1'b0)   begin n_err++; $display("FAIL bnd_timeout got=%b exp=0", to4); end
    tick();
    n_vec++; if (gnt4 !== 8'h10) begin n_err++; $display("FAIL bnd_next got=%h exp=10", gnt4); end
    n_vec++; if (idx4 !== 3'd4)  begin n_err++; $display("FAIL bnd_next_idx got=%0d exp=4", idx4); end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    req = 8'h18;
    tick();
    tick();
    n_vec++; if (gnt0 !== 8'h08) begin n_err++; $display("FAIL mid_pre got=%h exp=08", gnt0); end
    req   = 8'h08;
    rst_n = 1'b0;
    tick();
    n_vec++; if (gnt0 !== 8'h00) begin n_err++; $display("FAIL mid_rst_gnt got=%h exp=00", gnt0); end
    n_vec++; if (vld0 !== 1'b0)  begin n_err++; $display("FAIL mid_rst_vld got=%b exp=0", vld0); end
    n_vec++; if (idx0 !== 3'd0)  begin n_err++; $display("FAIL mid_rst_idx got=%0d exp=0", idx0); end
    n_vec++; if (to4 !== 1'b0)   begin n_err++; $display("FAIL mid_rst_to got=%b exp=0", to4); end
    rst_n = 1'b1;
    tick();
    n_vec++; if (gnt0 !== 8'h08) begin n_err++; $display("FAIL mid_resume_gnt got=%h exp=08", gnt0); end
    n_vec++; if (idx0 !== 3'd3)  begin n_err++; $display("FAIL mid_resume_idx got=%0d exp=3", idx0); end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 8'h00;
    test_reset();
    test_rotation();
    test_single();
    test_timeout();
    test_timeout_boundary();
    test_reset_mid_grant();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
